// File: rtl/dice_game_ctrl_if.sv
// Board-side bundle between push-buttons, the shared dice and the turn controller.
// master: board/dice side driving buttons and throw; slave: the controller.
interface dice_game_ctrl_if #(
  parameter int unsigned SCORE_W = 6
);
  logic               start;
  logic [1:0]         btn;
  logic [2:0]         dice_throw;
  logic               dice_roll;
  logic               turn;
  logic [2:0]         last_throw;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic               result_valid;
  logic               winner_valid;
  logic               winner;

  modport master (
    output start, btn, dice_throw,
    input  dice_roll, turn, last_throw, score_a, score_b, result_valid, winner_valid, winner
  );

  modport slave (
    input  start, btn, dice_throw,
    output dice_roll, turn, last_throw, score_a, score_b, result_valid, winner_valid, winner
  );
endinterface

// File: rtl/dice_game_ctrl.sv
// Two-player turn controller for one shared dice: rolls, captures, scores, declares a winner.
// Define ROLL_AGAIN_ON_SIX_EN to let a non-winning throw of 6 keep the turn.
module dice_game_ctrl #(
  parameter int unsigned MIN_ROLL_CYC = 4,
  parameter int unsigned TARGET       = 20,
  parameter int unsigned SCORE_W      = 6
) (
  input logic             clk,
  input logic             rst,
  dice_game_ctrl_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StWaitBtn, StRoll, StSettle, StScore, StDone} state_e;

  localparam int unsigned      CntW    = 8;
  localparam logic [CntW-1:0]  MinCyc  = CntW'(MIN_ROLL_CYC);
  localparam logic [SCORE_W:0] TargetW = (SCORE_W+1)'(TARGET);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic               turn_q, turn_d;
  logic [2:0]         last_throw_q, last_throw_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d, score_b_q, score_b_d;
  logic               winner_q, winner_d;
  logic               dice_roll_q, dice_roll_d;
  logic               result_valid_q, result_valid_d;
  logic               winner_valid_q, winner_valid_d;

  logic               btn_turn, throw_ok, win, keep_turn;
  logic [SCORE_W-1:0] score_cur, score_new;
  logic [SCORE_W:0]   score_sum;

  assign btn_turn  = bus_io.btn[turn_q];
  // cnt_inc counts the current ROLL cycle, so exit happens after exactly MIN_ROLL_CYC cycles
  assign cnt_inc   = (cnt_q >= MinCyc) ? cnt_q : cnt_q + CntW'(1);
  assign throw_ok  = (bus_io.dice_throw != 3'd0) && (bus_io.dice_throw != 3'd7);
  assign score_cur = turn_q ? score_b_q : score_a_q;
  assign score_sum = {1'b0, score_cur} + (SCORE_W+1)'(last_throw_q);
  assign score_new = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  assign win       = ({1'b0, score_new} >= TargetW);

`ifdef ROLL_AGAIN_ON_SIX_EN
  assign keep_turn = (last_throw_q == 3'd6);
`else
  assign keep_turn = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      turn_q         <= 1'b0;
      last_throw_q   <= '0;
      score_a_q      <= '0;
      score_b_q      <= '0;
      winner_q       <= 1'b0;
      dice_roll_q    <= 1'b0;
      result_valid_q <= 1'b0;
      winner_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      turn_q         <= turn_d;
      last_throw_q   <= last_throw_d;
      score_a_q      <= score_a_d;
      score_b_q      <= score_b_d;
      winner_q       <= winner_d;
      dice_roll_q    <= dice_roll_d;
      result_valid_q <= result_valid_d;
      winner_valid_q <= winner_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    turn_d       = turn_q;
    last_throw_d = last_throw_q;
    score_a_d    = score_a_q;
    score_b_d    = score_b_q;
    winner_d     = winner_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus_io.start) begin
          state_d   = StWaitBtn;
          score_a_d = '0;
          score_b_d = '0;
          turn_d    = 1'b0;
        end
      end
      StWaitBtn: begin
        if (btn_turn) begin
          state_d = StRoll;
          cnt_d   = '0;
        end
      end
      StRoll: begin
        cnt_d = cnt_inc;
        if (!btn_turn && (cnt_inc >= MinCyc)) state_d = StSettle;
      end
      StSettle: begin
        // An invalid face sends the same player back to roll again
        if (throw_ok) begin
          last_throw_d = bus_io.dice_throw;
          state_d      = StScore;
        end else begin
          state_d = StWaitBtn;
        end
      end
      StScore: begin
        if (turn_q) score_b_d = score_new;
        else        score_a_d = score_new;
        if (win) begin
          state_d  = StDone;
          winner_d = turn_q;
        end else begin
          state_d = StWaitBtn;
          if (!keep_turn) turn_d = ~turn_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the upcoming state so they line up with it
  always_comb begin
    dice_roll_d    = (state_d == StRoll);
    winner_valid_d = (state_d == StDone);
    result_valid_d = (state_q == StScore);
  end

  assign bus_io.dice_roll    = dice_roll_q;
  assign bus_io.turn         = turn_q;
  assign bus_io.last_throw   = last_throw_q;
  assign bus_io.score_a      = score_a_q;
  assign bus_io.score_b      = score_b_q;
  assign bus_io.result_valid = result_valid_q;
  assign bus_io.winner_valid = winner_valid_q;
  assign bus_io.winner       = winner_q;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Scoreboard bench for dice_game_ctrl: a game-level model predicts each scored result and roll
// length; independent monitors compare whenever the DUT pulses result_valid or ends a roll.
module tb_dice_game_ctrl;
  localparam int unsigned MinRoll  = 4;
  localparam int unsigned Target   = 20;
  localparam int unsigned ScoreW   = 6;
  localparam int          ScoreMax = (1 << ScoreW) - 1;

  typedef struct {
    int sa;
    int sb;
    int turn;
    int last;
    int wv;
    int win;
  } res_t;

  logic clk = 1'b0;
  logic rst;

  dice_game_ctrl_if #(.SCORE_W(ScoreW)) bus ();

  dice_game_ctrl #(
    .MIN_ROLL_CYC(MinRoll),
    .TARGET      (Target),
    .SCORE_W     (ScoreW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  res_t exp_q[$];
  int   len_q[$];
  bit   skip_len = 1'b0;
  int   run_len  = 0;
  res_t mon_e;

  // Game model
  int m_sa, m_sb, m_turn, m_last, m_done, m_winner;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1 && bus.result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected result_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("res score_a", bus.score_a, mon_e.sa);
        check("res score_b", bus.score_b, mon_e.sb);
        check("res turn", bus.turn, mon_e.turn);
        check("res last_throw", bus.last_throw, mon_e.last);
        check("res winner_valid", bus.winner_valid, mon_e.wv);
        if (mon_e.wv != 0) check("res winner", bus.winner, mon_e.win);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.dice_roll === 1'b1) begin
      run_len++;
    end else if (run_len > 0) begin
      if (skip_len) skip_len = 1'b0;
      else if (len_q.size() == 0) check("unexpected roll", run_len, 0);
      else check("roll length", run_len, len_q.pop_front());
      run_len = 0;
    end
  end

  task automatic model_reset();
    m_sa = 0; m_sb = 0; m_turn = 0; m_last = 0; m_done = 0; m_winner = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, " score_a"}, bus.score_a, m_sa);
    check({tag, " score_b"}, bus.score_b, m_sb);
    check({tag, " turn"}, bus.turn, m_turn);
    check({tag, " last_throw"}, bus.last_throw, m_last);
    check({tag, " winner_valid"}, bus.winner_valid, m_done);
    check({tag, " dice_roll"}, bus.dice_roll, 0);
    check({tag, " result_valid"}, bus.result_valid, 0);
    if (m_done != 0) check({tag, " winner"}, bus.winner, m_winner);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    m_sa = 0; m_sb = 0; m_turn = 0; m_done = 0;
    @(negedge clk);
    check_state("start");
  endtask

  // One roll by the player the model says holds the dice; noise adds the other button and start
  task automatic roll(input int h, input int v, input bit noise);
    int   p;
    int   sc;
    int   k;
    res_t r;
    logic [31:0] vv;
    p  = m_turn;
    vv = v;
    bus.btn    = 2'b00;
    bus.btn[p] = 1'b1;
    if (noise) begin
      bus.btn[1-p] = 1'b1;
      bus.start    = 1'b1;
    end
    bus.dice_throw = 3'($urandom_range(0, 7));
    len_q.push_back((h > int'(MinRoll)) ? h : int'(MinRoll));
    if (v >= 1 && v <= 6) begin
      m_last = v;
      if (p == 0) begin
        m_sa = (m_sa + v > ScoreMax) ? ScoreMax : m_sa + v;
        sc   = m_sa;
      end else begin
        m_sb = (m_sb + v > ScoreMax) ? ScoreMax : m_sb + v;
        sc   = m_sb;
      end
      if (sc >= int'(Target)) begin
        m_done   = 1;
        m_winner = p;
      end else begin
`ifdef ROLL_AGAIN_ON_SIX_EN
        if (v != 6) m_turn = 1 - p;
`else
        m_turn = 1 - p;
`endif
      end
      r.sa = m_sa; r.sb = m_sb; r.turn = m_turn; r.last = m_last;
      r.wv = m_done; r.win = m_winner;
      exp_q.push_back(r);
    end
    repeat (h) @(negedge clk);
    bus.btn        = 2'b00;
    bus.start      = 1'b0;
    bus.dice_throw = vv[2:0];
    k = 0;
    while (bus.dice_roll === 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("roll ends in time", (k < 300), 1);
    repeat (3) @(negedge clk);
    check_state("after roll");
  endtask

  task automatic buttons_in_done();
    bus.btn = 2'b11;
    repeat (6) begin
      @(negedge clk);
      check("done dice_roll", bus.dice_roll, 0);
    end
    bus.btn = 2'b00;
    @(negedge clk);
    check_state("done idle");
  endtask

  task automatic mid_roll_reset();
    skip_len       = 1'b1;
    bus.btn        = 2'b00;
    bus.btn[m_turn] = 1'b1;
    repeat (2) @(negedge clk);
    check("mid roll dice_roll", bus.dice_roll, 1);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    bus.btn = 2'b00;
    model_reset();
    check_state("mid reset");
    repeat (2) @(negedge clk);
    check_state("idle after reset");
  endtask

  initial begin
    int n;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.btn        = 2'b00;
    bus.dice_throw = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_state("reset");

    // Directed game
    do_start();
    roll(1, 5, 1'b0);
    roll(6, 3, 1'b1);
    roll(2, 0, 1'b0);
    roll(1, 7, 1'b0);
    roll(1, 2, 1'b0);
    roll(1, 1, 1'b0);
    roll(3, 1, 1'b0);
    roll(2, 6, 1'b0);
    while (!(m_sa == 18 && m_turn == 0)) begin
      if (m_turn == 0) roll(int'($urandom_range(1, 5)), (18 - m_sa > 6) ? 6 : 18 - m_sa, 1'b0);
      else             roll(1, 1, 1'b0);
    end
    roll(2, 2, 1'b0);
    check("directed winner_valid", bus.winner_valid, 1);
    buttons_in_done();
    do_start();

    // Random games; the first is cut short by a reset in the middle of a roll
    for (int g = 0; g < 4; g++) begin
      if (g > 0) do_start();
      n = 0;
      while (m_done == 0 && n < 200) begin
        if (g == 0 && n == 3) break;
        roll(int'($urandom_range(1, 8)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        n++;
      end
      if (g == 0) mid_roll_reset();
      else begin
        check("random game finished", m_done, 1);
        buttons_in_done();
      end
    end

    repeat (4) @(negedge clk);
    check("pending results", exp_q.size(), 0);
    check("pending rolls", len_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
